hamm_encoder_tx: RTL and testbench

Transmit-side companion to the Hamming(8,4) decoder. Accepts 4-bit data nibbles over a valid/ready handshake, encodes each into an 8-bit extended Hamming codeword, and serializes the codeword onto a one-bit channel with frame strobes. It also exposes each codeword in parallel so the decoder can be driven directly in loopback.

---
 rtl/hamm_pkg.sv | 25 ++
 rtl/hamm_encoder_tx_if.sv | 40 ++++
 rtl/hamm84_encode.sv | 12 +
 rtl/hamm_encoder_tx.sv | 151 +++++++++++++++
 tb/tb_hamm_encoder_tx.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hamm_pkg.sv
// Shared Hamming(8,4) definitions for the encoder and decoder.
// Parity equations here fix the decoder's syndrome layout.
package hamm_pkg;

  localparam int HAMM_N = 8;
  localparam int HAMM_K = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } tx_state_e;

  // Returns c3..c0; c0 makes the whole word even parity.
  function automatic logic [3:0] hamm84_parity(
    input logic [3:0] d
  );
    logic [2:0] p;
    p[2] = d[3] ^ d[2] ^ d[1];
    p[1] = d[3] ^ d[2] ^ d[0];
    p[0] = d[3] ^ d[1] ^ d[0];
    return {p, ^{d, p}};
  endfunction

endpackage

// File: rtl/hamm_encoder_tx_if.sv
// Nibble handshake plus serial and parallel codeword outputs.
// The DUT side uses slave; the source/sink side uses master.
interface hamm_encoder_tx_if;
  import hamm_pkg::*;

  logic [HAMM_K-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              tx_bit;
  logic              tx_valid;
  logic              tx_sof;
  logic              tx_eof;
  logic [HAMM_N-1:0] code_out;
  logic              code_valid;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  tx_bit,
    input  tx_valid,
    input  tx_sof,
    input  tx_eof,
    input  code_out,
    input  code_valid
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output tx_bit,
    output tx_valid,
    output tx_sof,
    output tx_eof,
    output code_out,
    output code_valid
  );

endinterface

// File: rtl/hamm84_encode.sv
// Combinational Hamming(8,4) encoder: data on c7..c4,
// parity on c3..c0.
module hamm84_encode
  import hamm_pkg::*;
(
  input  logic [HAMM_K-1:0] d,
  output logic [HAMM_N-1:0] c
);

  assign c = {d, hamm84_parity(d)};

endmodule

// File: rtl/hamm_encoder_tx.sv
// Hamming(8,4) transmitter: one-entry hold buffer feeding
// a serializer with frame strobes and optional inter-frame gap.
module hamm_encoder_tx
  import hamm_pkg::*;
#(
  parameter int GAP_CYCLES = 0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input logic         clk,
  input logic         reset,
  hamm_encoder_tx_if.slave bus
);

  localparam int GW =
    ($clog2(GAP_CYCLES + 1) > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_e         st_q;
  tx_state_e         st_d;
  logic [HAMM_N-1:0] enc;
  logic [HAMM_N-1:0] hold_q;
  logic              hold_v;
  logic [HAMM_N-1:0] sh_q;
  logic [HAMM_N-1:0] sh_d;
  logic [2:0]        cnt;
  logic [2:0]        cnt_d;
  logic [GW-1:0]     gap_cnt;
  logic [GW-1:0]     gap_d;
  logic              load;
  logic              accept;
  logic [2:0]        idx;
  logic              shift_d;

  logic              bit_q;
  logic              val_q;
  logic              sof_q;
  logic              eof_q;
  logic [HAMM_N-1:0] code_q;
  logic              cv_q;

  hamm84_encode u_enc (
    .d (bus.din),
    .c (enc)
  );

  // Ready depends only on the registered flag, so an accept
  // can never land on the same edge as a transfer.
  assign accept = bus.din_valid & ~hold_v;

  // Next state, counters and the hold-to-shifter transfer.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt;
    gap_d = gap_cnt;
    sh_d  = sh_q;
    load  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (hold_v) load = 1'b1;
      end
      SHIFT: begin
        if (cnt == 3'd7) begin
          if (GAP_CYCLES > 0) begin
            st_d  = GAP;
            gap_d = '0;
          end else if (hold_v) begin
            load = 1'b1;
          end else begin
            st_d = IDLE;
          end
        end else begin
          cnt_d = cnt + 3'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (hold_v) load = 1'b1;
          else        st_d = IDLE;
        end else begin
          gap_d = gap_cnt + GW'(1);
        end
      end
      default: st_d = IDLE;
    endcase
    if (load) begin
      st_d  = SHIFT;
      sh_d  = hold_q;
      cnt_d = '0;
    end
  end

  assign idx     = MSB_FIRST ? (3'd7 - cnt_d) : cnt_d;
  assign shift_d = (st_d == SHIFT);

  // State, shifter and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= IDLE;
      sh_q    <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
    end else begin
      st_q    <= st_d;
      sh_q    <= sh_d;
      cnt     <= cnt_d;
      gap_cnt <= gap_d;
    end
  end

  // One-entry hold buffer between the source and the shifter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      hold_v <= 1'b0;
    end else if (accept) begin
      hold_q <= enc;
      hold_v <= 1'b1;
    end else if (load) begin
      hold_v <= 1'b0;
    end
  end

  // Registered serial outputs describe the cycle being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_q  <= 1'b0;
      val_q  <= 1'b0;
      sof_q  <= 1'b0;
      eof_q  <= 1'b0;
      code_q <= '0;
      cv_q   <= 1'b0;
    end else begin
      bit_q <= shift_d & sh_d[idx];
      val_q <= shift_d;
      sof_q <= shift_d & (cnt_d == 3'd0);
      eof_q <= shift_d & (cnt_d == 3'd7);
      cv_q  <= load;
      if (load) code_q <= hold_q;
    end
  end

  assign bus.din_ready  = ~hold_v;
  assign bus.tx_bit     = bit_q;
  assign bus.tx_valid   = val_q;
  assign bus.tx_sof     = sof_q;
  assign bus.tx_eof     = eof_q;
  assign bus.code_out   = code_q;
  assign bus.code_valid = cv_q;

endmodule

// File: tb/tb_hamm_encoder_tx.sv
// Directed bench for hamm_encoder_tx: encoding, framing,
// back-to-back, gap, loopback decode, bit order, reset.
module tb_hamm_encoder_tx;

  logic       clk;
  logic       reset;
  logic [3:0] din;
  logic       dv;
  int         sel;
  int         n_chk;
  int         n_fail;

  logic       o_rdy;
  logic       o_bit;
  logic       o_val;
  logic       o_sof;
  logic       o_eof;
  logic [7:0] o_code;
  logic       o_cv;

  logic [3:0] ref_d;
  logic [7:0] ref_c;

  logic [7:0] tbl [16] = '{
    8'h00, 8'h17, 8'h2B, 8'h3C, 8'h4D, 8'h5A, 8'h66, 8'h71,
    8'h8E, 8'h99, 8'hA5, 8'hB2, 8'hC3, 8'hD4, 8'hE8, 8'hFF
  };

  hamm_encoder_tx_if b0 ();
  hamm_encoder_tx_if b1 ();
  hamm_encoder_tx_if b2 ();

  assign b0.din       = din;
  assign b1.din       = din;
  assign b2.din       = din;
  assign b0.din_valid = dv && (sel == 0);
  assign b1.din_valid = dv && (sel == 1);
  assign b2.din_valid = dv && (sel == 2);

  hamm_encoder_tx #(.GAP_CYCLES(0), .MSB_FIRST(1'b1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  hamm_encoder_tx #(.GAP_CYCLES(3), .MSB_FIRST(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  hamm_encoder_tx #(.GAP_CYCLES(0), .MSB_FIRST(1'b0)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  hamm84_encode u_ref (
    .d (ref_d),
    .c (ref_c)
  );

  always #5 clk = ~clk;

  always_comb begin
    o_rdy  = b0.din_ready;
    o_bit  = b0.tx_bit;
    o_val  = b0.tx_valid;
    o_sof  = b0.tx_sof;
    o_eof  = b0.tx_eof;
    o_code = b0.code_out;
    o_cv   = b0.code_valid;
    if (sel == 1) begin
      o_rdy  = b1.din_ready;
      o_bit  = b1.tx_bit;
      o_val  = b1.tx_valid;
      o_sof  = b1.tx_sof;
      o_eof  = b1.tx_eof;
      o_code = b1.code_out;
      o_cv   = b1.code_valid;
    end else if (sel == 2) begin
      o_rdy  = b2.din_ready;
      o_bit  = b2.tx_bit;
      o_val  = b2.tx_valid;
      o_sof  = b2.tx_sof;
      o_eof  = b2.tx_eof;
      o_code = b2.code_out;
      o_cv   = b2.code_valid;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent syndrome decoder used for loopback.
  function automatic logic [3:0] dec(input logic [7:0] c);
    logic [2:0] s;
    logic [7:0] f;
    s[2] = c[7] ^ c[6] ^ c[5] ^ c[3];
    s[1] = c[7] ^ c[6] ^ c[4] ^ c[2];
    s[0] = c[7] ^ c[5] ^ c[4] ^ c[1];
    f = c;
    case (s)
      3'b111: f[7] = ~f[7];
      3'b110: f[6] = ~f[6];
      3'b101: f[5] = ~f[5];
      3'b011: f[4] = ~f[4];
      3'b100: f[3] = ~f[3];
      3'b010: f[2] = ~f[2];
      3'b001: f[1] = ~f[1];
      default: ;
    endcase
    return f[7:4];
  endfunction

  task automatic send(input logic [3:0] d);
    int n;
    n = 0;
    @(negedge clk);
    din = d;
    dv  = 1'b1;
    while (!o_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("send_rdy", o_rdy, 1);
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic grab(
    output logic [7:0] ser,
    output logic [7:0] par,
    output logic       cv,
    output logic       ok,
    output int         lat
  );
    ser = '0;
    par = '0;
    cv  = 1'b0;
    ok  = 1'b1;
    lat = 0;
    while (!o_sof && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!o_sof) ok = 1'b0;
    par = o_code;
    cv  = o_cv;
    for (int i = 0; i < 8; i++) begin
      ser = {ser[6:0], o_bit};
      if (!o_val || (o_sof != (i == 0)) || (o_eof != (i == 7)))
        ok = 1'b0;
      if (i < 7) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0]  ser;
    logic [7:0]  par;
    logic [15:0] s16;
    logic        cv;
    logic        ok;
    int          lat;
    int          run;
    int          g;
    int          n;

    clk    = 1'b0;
    reset  = 1'b0;
    din    = '0;
    dv     = 1'b0;
    sel    = 0;
    ref_d  = '0;
    n_chk  = 0;
    n_fail = 0;

    // Reset state
    #12;
    chk("rst_bit", o_bit, 0);
    chk("rst_val", o_val, 0);
    chk("rst_sof", o_sof, 0);
    chk("rst_eof", o_eof, 0);
    chk("rst_cv", o_cv, 0);
    chk("rst_code", o_code, 8'h00);
    chk("rst_rdy", o_rdy, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Encoding values and serial framing, MSB first
    send(4'hB);
    chk("b_rdy_lo", o_rdy, 0);
    grab(ser, par, cv, ok, lat);
    chk("b_lat", lat, 1);
    chk("b_code", par, 8'hB2);
    chk("b_cv", cv, 1);
    chk("b_ser", ser, 8'hB2);
    chk("b_frame", ok, 1);
    send(4'h0);
    grab(ser, par, cv, ok, lat);
    chk("z_code", par, 8'h00);
    chk("z_frame", ok, 1);
    send(4'hF);
    grab(ser, par, cv, ok, lat);
    chk("f_code", par, 8'hFF);
    chk("f_ser", ser, 8'hFF);
    chk("f_frame", ok, 1);

    // Loopback through the decoder, with single-bit flips
    for (int k = 0; k < 16; k++) begin
      ref_d = 4'(k);
      send(4'(k));
      grab(ser, par, cv, ok, lat);
      chk("lb_code", par, tbl[k]);
      chk("lb_ser", ser, tbl[k]);
      chk("lb_ref", ref_c, tbl[k]);
      chk("lb_frame", ok, 1);
      chk("lb_dec", dec(par), k);
      for (int b = 1; b < 8; b++) begin
        chk("lb_flip", dec(par ^ (8'h01 << b)), k);
      end
    end

    // Back-to-back frames
    @(negedge clk);
    din = 4'h1;
    dv  = 1'b1;
    @(negedge clk);
    chk("b2b_rdy_lo", o_rdy, 0);
    din = 4'h2;
    @(negedge clk);
    chk("b2b_rdy_hi", o_rdy, 1);
    run = 0;
    s16 = '0;
    ok  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i == 1) dv = 1'b0;
      if (i < 16) begin
        if (o_val) run++;
        s16 = {s16[14:0], o_bit};
      end
      if (o_sof != (i == 0 || i == 8)) ok = 1'b0;
      if (o_eof != (i == 7 || i == 15)) ok = 1'b0;
      if (i < 16) @(negedge clk);
    end
    chk("b2b_run", run, 16);
    chk("b2b_end", o_val, 0);
    chk("b2b_ser", s16, 16'h172B);
    chk("b2b_strobes", ok, 1);

    // Inter-frame gap of three idle cycles
    sel = 1;
    send(4'h1);
    send(4'h2);
    n = 0;
    while (!o_eof && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("gap_eof", o_eof, 1);
    g = 0;
    n = 0;
    @(negedge clk);
    while (!o_sof && n < 40) begin
      if (!o_val) g++;
      @(negedge clk);
      n++;
    end
    chk("gap_len", g, 3);
    chk("gap_code", o_code, 8'h2B);
    chk("gap_cv", o_cv, 1);
    repeat (12) @(negedge clk);

    // LSB-first bit order
    sel = 2;
    send(4'hB);
    grab(ser, par, cv, ok, lat);
    chk("lsb_ser", ser, 8'h4D);
    chk("lsb_code", par, 8'hB2);
    chk("lsb_frame", ok, 1);

    // Reset mid-frame with a nibble waiting in the hold register
    sel = 0;
    @(negedge clk);
    send(4'h5);
    @(negedge clk);
    chk("mid_sof", o_sof, 1);
    din = 4'h6;
    dv  = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    chk("mid_rdy_lo", o_rdy, 0);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_val", o_val, 0);
    chk("mid_bit", o_bit, 0);
    chk("mid_eof", o_eof, 0);
    chk("mid_code", o_code, 8'h00);
    chk("mid_rdy", o_rdy, 1);
    @(negedge clk);
    reset = 1'b1;
    run = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_val || o_eof) run++;
    end
    chk("mid_quiet", run, 0);
    send(4'h9);
    grab(ser, par, cv, ok, lat);
    chk("post_lat", lat, 1);
    chk("post_code", par, 8'h99);
    chk("post_ser", ser, 8'h99);
    chk("post_frame", ok, 1);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
